// File: rtl/grid_output_reader.sv
// grid_output_reader: drains east-edge spike packets into per-tick output bitmaps
//   clk, rst          clock, synchronous active-high reset
//   tick              one-cycle global tick pulse that closes the current frame
//   empty_in, ren_out edge buffer handshake; packet_in valid the cycle after ren_out
//   frame_*           held frame (bitmap, tick number, packet count) over valid/ready
//   overflow_error    sticky: a frame closed while the previous one was still held
//   range_error       sticky: a packet decoded to an index >= NUM_OUTPUTS
module grid_output_reader #(
    parameter int PACKET_WIDTH = 30,
    parameter int NUM_AXONS    = 256,
    parameter int NUM_TICKS    = 16,
    parameter int NUM_OUTPUTS  = 256,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    empty_in,
    input  logic [PACKET_WIDTH-1:0] packet_in,
    output logic                    ren_out,
    output logic [NUM_OUTPUTS-1:0]  frame_spikes,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic [COUNT_WIDTH-1:0]  frame_index,
    output logic [COUNT_WIDTH-1:0]  frame_packets,
    output logic                    overflow_error,
    output logic                    range_error
);
    localparam int AW = $clog2(NUM_AXONS);
    localparam int TW = $clog2(NUM_TICKS);
    typedef enum logic {IDLE, READ} state_t;
    state_t                   state_q, state_d;
    logic [NUM_OUTPUTS-1:0]   acc_q, acc_d, acc_next, hit_vec, spikes_q, spikes_d;
    logic [COUNT_WIDTH-1:0]   acc_count_q, acc_count_d, cnt_next;
    logic [COUNT_WIDTH-1:0]   tick_cnt_q, tick_cnt_d, index_q, index_d, packets_q, packets_d;
    logic                     valid_q, valid_d, ovf_q, ovf_d, rerr_q, rerr_d;
    logic [AW-1:0]            idx;
    logic                     rd, in_range, load;
    logic                     unused_bits;

    assign idx      = packet_in[TW +: AW];
    assign rd       = state_q == READ;
    assign in_range = {1'b0, idx} < (AW + 1)'(NUM_OUTPUTS);
    // Tick and routing fields carry nothing for the host side.
    assign unused_bits = ^{packet_in[PACKET_WIDTH-1:TW+AW], packet_in[TW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && !empty_in) ? READ : IDLE;
    end

    // Gated by rst so no buffer word is popped while the block is held in reset.
    always_comb begin
        ren_out = state_q == IDLE && !empty_in && !rst;
    end

    // Out-of-range indices match no bit, so they fall out of the bitmap naturally.
    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) hit_vec[i] = rd && idx == AW'(i);
    end

    always_comb begin
        acc_next    = acc_q | hit_vec;
        cnt_next    = (rd && !(&acc_count_q)) ? acc_count_q + 1'b1 : acc_count_q;
        load        = tick && (!valid_q || frame_ready);
        acc_d       = tick ? '0 : acc_next;
        acc_count_d = tick ? '0 : cnt_next;
        tick_cnt_d  = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
        valid_d     = load || (valid_q && !frame_ready);
        spikes_d    = load ? acc_next : spikes_q;
        packets_d   = load ? cnt_next : packets_q;
        index_d     = load ? tick_cnt_q : index_q;
        ovf_d       = ovf_q || (tick && valid_q && !frame_ready);
        rerr_d      = rerr_q || (rd && !in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_count_q <= '0;
            tick_cnt_q  <= '0;
            valid_q     <= 1'b0;
            spikes_q    <= '0;
            packets_q   <= '0;
            index_q     <= '0;
            ovf_q       <= 1'b0;
            rerr_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_count_q <= acc_count_d;
            tick_cnt_q  <= tick_cnt_d;
            valid_q     <= valid_d;
            spikes_q    <= spikes_d;
            packets_q   <= packets_d;
            index_q     <= index_d;
            ovf_q       <= ovf_d;
            rerr_q      <= rerr_d;
        end
    end

    assign frame_spikes   = spikes_q;
    assign frame_valid    = valid_q;
    assign frame_index    = index_q;
    assign frame_packets  = packets_q;
    assign overflow_error = ovf_q;
    assign range_error    = rerr_q;
endmodule
